// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit_if
//  Brief    : Fetch-stage bus bundle: instruction-memory request/response,
//             downstream instruction handshake, redirect input and status.
//  Revision : 1.0  initial release
// ============================================================================
interface pc_fetch_unit_if #(
  parameter int XLEN   = 32,
  parameter int INSN_W = 32,
  parameter int CNT_W  = 16
);
  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;
  logic              ins_valid;
  logic              ins_ready;
  logic [INSN_W-1:0] ins_out;
  logic [XLEN-1:0]   pc_out;
  logic              redir_valid;
  logic [XLEN-1:0]   redir_target;
  logic              misalign_err;
  logic [CNT_W-1:0]  fetch_cnt;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, ins_valid, ins_out, pc_out, misalign_err, fetch_cnt,
    input  imem_ack, imem_rdata, ins_ready, redir_valid, redir_target
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req, imem_addr, ins_valid, ins_out, pc_out, misalign_err, fetch_cnt,
    output imem_ack, imem_rdata, ins_ready, redir_valid, redir_target
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Brief    : Fetch-stage sequencer. Holds the PC, requests words from
//             instruction memory, hands them downstream via valid/ready and
//             accepts one-cycle redirects from execute.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              INSN_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.master fetch
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]        r_state;
  logic [XLEN-1:0]   r_pc;
  logic [INSN_W-1:0] r_ins;
  logic [XLEN-1:0]   r_pc_out;
  logic              r_ins_valid;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_handshake;
  logic              w_misaligned;
  logic [XLEN-1:0]   w_target_aligned;

  // HOLD is the only state in which ins_valid is high, so the handshake is
  // simply valid & ready.
  assign w_handshake      = r_ins_valid & fetch.ins_ready;
  assign w_misaligned     = fetch.redir_valid & (fetch.redir_target[1:0] != 2'b00);
  assign w_target_aligned = {fetch.redir_target[XLEN-1:2], 2'b00};

  assign fetch.imem_req     = (r_state == FETCH);
  assign fetch.imem_addr    = r_pc;
  assign fetch.ins_valid    = r_ins_valid;
  assign fetch.ins_out      = r_ins;
  assign fetch.pc_out       = r_pc_out;
  assign fetch.misalign_err = r_misalign;
  assign fetch.fetch_cnt    = r_cnt;

  // Misalignment flag: one-cycle pulse following a redirect with low bits set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misaligned;
    end
  end

  // Completed-handshake counter; a handshake still counts when a redirect
  // arrives in the same HOLD cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_handshake) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // PC / state sequencing; a redirect overrides every other event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_ins       <= '0;
      r_pc_out    <= '0;
      r_ins_valid <= 1'b0;
    end else if (fetch.redir_valid) begin
      r_pc        <= w_target_aligned;
      r_state     <= FETCH;
      r_ins_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (fetch.imem_ack) begin
            r_ins       <= fetch.imem_rdata;
            r_pc_out    <= r_pc;
            r_ins_valid <= 1'b1;
            r_pc        <= r_pc + XLEN'(4);
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (fetch.ins_ready) begin
            r_ins_valid <= 1'b0;
            r_state     <= FETCH;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_ins_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Brief    : Self-checking bench for pc_fetch_unit: directed vector table,
//             asynchronous-reset sequence and randomized run against a
//             behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] target;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
    logic        e_mis;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[$];

  // Reference model state: "started" means the unit has left reset idle;
  // an instruction is being held whenever m_valid is set, otherwise fetching.
  logic        m_started;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_pcout;
  logic [15:0] m_cnt;
  logic        m_mis;

  pc_fetch_unit_if #(.XLEN(32), .INSN_W(32), .CNT_W(16)) bus ();

  pc_fetch_unit #(.XLEN(32), .INSN_W(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .fetch (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic redir, input logic [31:0] target);
    bus.imem_ack     = ack;
    bus.imem_rdata   = rdata;
    bus.ins_ready    = ready;
    bus.redir_valid  = redir;
    bus.redir_target = target;
  endtask

  task automatic add(input logic ack, input logic [31:0] rdata, input logic ready,
                     input logic redir, input logic [31:0] target,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_ins, input logic [31:0] e_pc,
                     input logic [15:0] e_cnt, input logic e_mis);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.target = target;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_ins = e_ins;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_mis = e_mis;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_valid = 1'b0; m_pc = 32'h0; m_ins = 32'h0;
    m_pcout = 32'h0; m_cnt = 16'h0; m_mis = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step(input logic ack, input logic [31:0] rdata, input logic ready,
                            input logic redir, input logic [31:0] target);
    logic fetching;
    logic hs;
    fetching = m_started && !m_valid;
    hs       = m_valid && ready;
    m_mis    = redir && (target % 4 != 0);
    if (hs) m_cnt = m_cnt + 16'd1;
    if (redir) begin
      m_pc = target - (target % 4);
      m_valid = 1'b0;
      m_started = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (fetching && ack) begin
      m_ins = rdata; m_pcout = m_pc; m_pc = m_pc + 32'd4; m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_req"},   {31'b0, bus.imem_req},     {31'b0, m_started && !m_valid});
    chk({tag, "_addr"},  bus.imem_addr,             m_pc);
    chk({tag, "_valid"}, {31'b0, bus.ins_valid},    {31'b0, m_valid});
    chk({tag, "_ins"},   bus.ins_out,               m_ins);
    chk({tag, "_pcout"}, bus.pc_out,                m_pcout);
    chk({tag, "_cnt"},   {16'b0, bus.fetch_cnt},    {16'b0, m_cnt});
    chk({tag, "_mis"},   {31'b0, bus.misalign_err}, {31'b0, m_mis});
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Directed table: inputs for the cycle, outputs expected before its edge.
    add(0, 0,          0, 0, 0,           0, 32'h0,   0, 32'h0,      32'h0,   0, 0); // idle
    add(1, K|32'h0,    1, 0, 0,           1, 32'h0,   0, 32'h0,      32'h0,   0, 0);
    add(0, 0,          1, 0, 0,           0, 32'h4,   1, K|32'h0,    32'h0,   0, 0);
    add(1, K|32'h4,    1, 0, 0,           1, 32'h4,   0, K|32'h0,    32'h0,   1, 0);
    add(0, 0,          1, 0, 0,           0, 32'h8,   1, K|32'h4,    32'h4,   1, 0);
    add(1, K|32'h8,    1, 0, 0,           1, 32'h8,   0, K|32'h4,    32'h4,   2, 0);
    add(0, 0,          1, 0, 0,           0, 32'hC,   1, K|32'h8,    32'h8,   2, 0);
    add(1, K|32'hC,    1, 0, 0,           1, 32'hC,   0, K|32'h8,    32'h8,   3, 0);
    add(0, 0,          1, 0, 0,           0, 32'h10,  1, K|32'hC,    32'hC,   3, 0);
    add(1, K|32'h10,   0, 0, 0,           1, 32'h10,  0, K|32'hC,    32'hC,   4, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0,        0, 0, 0,           0, 32'h14,  1, K|32'h10,   32'h10,  4, 0); // backpressure
    add(0, 0,          1, 0, 0,           0, 32'h14,  1, K|32'h10,   32'h10,  4, 0);
    add(1, 32'hDEAD,   0, 1, 32'h100,     1, 32'h14,  0, K|32'h10,   32'h10,  5, 0); // redirect + ack
    add(0, 0,          0, 0, 0,           1, 32'h100, 0, K|32'h10,   32'h10,  5, 0);
    add(1, 32'h1111_1111, 0, 0, 0,        1, 32'h100, 0, K|32'h10,   32'h10,  5, 0);
    add(0, 0,          0, 1, 32'h203,     0, 32'h104, 1, 32'h1111_1111, 32'h100, 5, 0); // redirect in HOLD
    add(0, 0,          0, 0, 0,           1, 32'h200, 0, 32'h1111_1111, 32'h100, 5, 1);
    add(0, 0,          0, 1, 32'hFFFF_FFFC, 1, 32'h200, 0, 32'h1111_1111, 32'h100, 5, 0);
    add(1, 32'h2222_2222, 0, 0, 0,        1, 32'hFFFF_FFFC, 0, 32'h1111_1111, 32'h100, 5, 0);
    add(0, 0,          1, 1, 32'h300,     0, 32'h0,   1, 32'h2222_2222, 32'hFFFF_FFFC, 5, 0); // wrap, ready+redirect
    add(0, 0,          0, 0, 0,           1, 32'h300, 0, 32'h2222_2222, 32'hFFFF_FFFC, 6, 0);

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'b0, bus.imem_req},     32'h0);
    chk("rst_addr",  bus.imem_addr,             32'h0);
    chk("rst_valid", {31'b0, bus.ins_valid},    32'h0);
    chk("rst_ins",   bus.ins_out,               32'h0);
    chk("rst_pcout", bus.pc_out,                32'h0);
    chk("rst_cnt",   {16'b0, bus.fetch_cnt},    32'h0);
    chk("rst_mis",   {31'b0, bus.misalign_err}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].ack, tbl[i].rdata, tbl[i].ready, tbl[i].redir, tbl[i].target);
      @(negedge clk);
      chk($sformatf("v%0d_req", i),   {31'b0, bus.imem_req},     {31'b0, tbl[i].e_req});
      chk($sformatf("v%0d_addr", i),  bus.imem_addr,             tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.ins_valid},    {31'b0, tbl[i].e_valid});
      chk($sformatf("v%0d_ins", i),   bus.ins_out,               tbl[i].e_ins);
      chk($sformatf("v%0d_pcout", i), bus.pc_out,                tbl[i].e_pc);
      chk($sformatf("v%0d_cnt", i),   {16'b0, bus.fetch_cnt},    {16'b0, tbl[i].e_cnt});
      chk($sformatf("v%0d_mis", i),   {31'b0, bus.misalign_err}, {31'b0, tbl[i].e_mis});
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a FETCH cycle (no clock edge between).
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req",   {31'b0, bus.imem_req},  32'h0);
    chk("arst_valid", {31'b0, bus.ins_valid}, 32'h0);
    chk("arst_addr",  bus.imem_addr,          32'h0);
    chk("arst_cnt",   {16'b0, bus.fetch_cnt}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rel_idle_req", {31'b0, bus.imem_req}, 32'h0);
    @(negedge clk);
    chk("rel_fetch_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("rel_fetch_addr", bus.imem_addr,         32'h0);

    // Randomized run against the model from a fresh reset.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic        ack, ready, redir;
      logic [31:0] rdata, target;
      ack    = ($urandom_range(0, 9) < 6);
      ready  = ($urandom_range(0, 9) < 5);
      redir  = ($urandom_range(0, 99) < 8);
      rdata  = $urandom;
      target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 4095));
      drive(ack, rdata, ready, redir, target);
      @(negedge clk);
      check_model($sformatf("r%0d", c));
      model_step(ack, rdata, ready, redir, target);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
